// File: rtl/fighter_pkg.sv
// Shared definitions for the fighting-game player controller: action codes,
// controller states and the position distance helper.
package fighter_pkg;

  localparam int unsigned ACT_W  = 3;
  localparam int unsigned DIST_W = 16;

  localparam logic [ACT_W-1:0] KICK  = 3'b000;
  localparam logic [ACT_W-1:0] PUNCH = 3'b001;
  localparam logic [ACT_W-1:0] WAIT  = 3'b010;
  localparam logic [ACT_W-1:0] JUMP  = 3'b011;
  localparam logic [ACT_W-1:0] LEFT  = 3'b100;
  localparam logic [ACT_W-1:0] RIGHT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JUMP = 2'd1,
    ST_COOL = 2'd2,
    ST_KO   = 2'd3
  } state_t;

  // Unsigned |a-b|; callers truncate to their own position width + 1.
  function automatic logic [DIST_W-1:0] abs_diff(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/fighter_player_ctrl_if.sv
// Action/opponent inputs and player status outputs of one fighter controller.
interface fighter_player_ctrl_if #(
  parameter int unsigned POS_W    = 2,
  parameter int unsigned HEALTH_W = 2
) ();
  import fighter_pkg::*;

  logic                act_valid;
  logic [ACT_W-1:0]    act;
  logic [POS_W-1:0]    opp_pos;
  logic                opp_airborne;
  logic                hit_in;
  logic [HEALTH_W-1:0] hit_dmg;

  logic [POS_W-1:0]    pos;
  logic                airborne;
  logic                busy;
  logic                strike;
  logic [HEALTH_W-1:0] strike_dmg;
  logic [HEALTH_W-1:0] health;
  logic                ko;

  modport master (
    output act_valid, act, opp_pos, opp_airborne, hit_in, hit_dmg,
    input  pos, airborne, busy, strike, strike_dmg, health, ko
  );

  modport slave (
    input  act_valid, act, opp_pos, opp_airborne, hit_in, hit_dmg,
    output pos, airborne, busy, strike, strike_dmg, health, ko
  );

endinterface

// File: rtl/fighter_timer.sv
// Loadable down-counter shared by the jump window and the attack cooldown.
module fighter_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // High during the final cycle of the loaded interval.
  assign o_done_c = (r_cnt <= W'(1));

endmodule

// File: rtl/fighter_player_ctrl.sv
// Per-player controller: action decode, 1-D movement with blocking, jump and
// attack timing, strike generation, saturating health and sticky knockout.
module fighter_player_ctrl #(
  parameter int unsigned HEALTH_W     = 2,
  parameter int unsigned HEALTH_INIT  = 3,
  parameter int unsigned NUM_POS      = 3,
  parameter int unsigned START_POS    = 0,
  parameter int unsigned PUNCH_RANGE  = 1,
  parameter int unsigned KICK_RANGE   = 2,
  parameter int unsigned PUNCH_DMG    = 1,
  parameter int unsigned KICK_DMG     = 2,
  parameter int unsigned JUMP_CYCLES  = 2,
  parameter int unsigned ATK_COOLDOWN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fighter_player_ctrl_if.slave bus
);
  import fighter_pkg::*;

  localparam int unsigned POS_W   = (NUM_POS > 2) ? $clog2(NUM_POS) : 1;
  localparam int unsigned CNT_MAX = (JUMP_CYCLES > ATK_COOLDOWN) ? JUMP_CYCLES : ATK_COOLDOWN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    w_pos_nxt;
  logic [HEALTH_W-1:0] r_health;
  logic [HEALTH_W-1:0] w_health_nxt;
  logic                r_airborne;
  logic                r_busy;
  logic                r_strike;
  logic                r_ko;
  logic [HEALTH_W-1:0] r_strike_dmg;
  logic                w_strike_nxt;
  logic [HEALTH_W-1:0] w_strike_dmg_nxt;

  logic                w_tmr_load;
  logic [CNT_W-1:0]    w_tmr_val;
  logic                w_tmr_done;

  logic [POS_W:0]      w_dist;
  logic [HEALTH_W:0]   w_health_diff;
  logic                w_hit_ok;

  fighter_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done_c   (w_tmr_done)
  );

  assign w_dist        = (POS_W+1)'(abs_diff(DIST_W'(r_pos), DIST_W'(bus.opp_pos)));
  // One extra bit so an over-large hit shows up as a borrow.
  assign w_health_diff = {1'b0, r_health} - {1'b0, bus.hit_dmg};
  assign w_hit_ok      = bus.hit_in & ~r_airborne & ~r_ko;

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_health_nxt     = r_health;
    w_strike_nxt     = 1'b0;
    w_strike_dmg_nxt = '0;
    w_tmr_load       = 1'b0;
    w_tmr_val        = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.act_valid) begin
          case (bus.act)
            KICK, PUNCH: begin
              if (bus.act == KICK) begin
                w_strike_nxt = (32'(w_dist) <= KICK_RANGE) && !bus.opp_airborne;
                w_strike_dmg_nxt = w_strike_nxt ? HEALTH_W'(KICK_DMG) : '0;
              end else begin
                w_strike_nxt = (32'(w_dist) <= PUNCH_RANGE) && !bus.opp_airborne;
                w_strike_dmg_nxt = w_strike_nxt ? HEALTH_W'(PUNCH_DMG) : '0;
              end
              if (ATK_COOLDOWN > 0) begin
                w_state_nxt = ST_COOL;
                w_tmr_load  = 1'b1;
                w_tmr_val   = CNT_W'(ATK_COOLDOWN);
              end
            end
            JUMP: begin
              w_state_nxt = ST_JUMP;
              w_tmr_load  = 1'b1;
              w_tmr_val   = CNT_W'(JUMP_CYCLES);
            end
            LEFT: begin
              if (r_pos != '0 && (r_pos - POS_W'(1)) != bus.opp_pos) begin
                w_pos_nxt = r_pos - POS_W'(1);
              end
            end
            RIGHT: begin
              if (r_pos != POS_W'(NUM_POS - 1) && (r_pos + POS_W'(1)) != bus.opp_pos) begin
                w_pos_nxt = r_pos + POS_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      ST_JUMP, ST_COOL: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_KO: ;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Incoming hit; knockout overrides any transition chosen above.
    if (w_hit_ok) begin
      if (w_health_diff[HEALTH_W] || w_health_diff[HEALTH_W-1:0] == '0) begin
        w_health_nxt = '0;
        w_state_nxt  = ST_KO;
      end else begin
        w_health_nxt = w_health_diff[HEALTH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pos        <= POS_W'(START_POS);
      r_health     <= HEALTH_W'(HEALTH_INIT);
      r_airborne   <= 1'b0;
      r_busy       <= 1'b0;
      r_strike     <= 1'b0;
      r_strike_dmg <= '0;
      r_ko         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_health     <= w_health_nxt;
      r_airborne   <= (w_state_nxt == ST_JUMP);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_strike     <= w_strike_nxt;
      r_strike_dmg <= w_strike_dmg_nxt;
      r_ko         <= (w_state_nxt == ST_KO);
    end
  end

  assign bus.pos        = r_pos;
  assign bus.airborne   = r_airborne;
  assign bus.busy       = r_busy;
  assign bus.strike     = r_strike;
  assign bus.strike_dmg = r_strike_dmg;
  assign bus.health     = r_health;
  assign bus.ko         = r_ko;

endmodule

// File: tb/tb_fighter_player_ctrl.sv
// Directed bench for fighter_player_ctrl with default parameters.
module tb_fighter_player_ctrl;
  import fighter_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fighter_player_ctrl_if #(.POS_W(2), .HEALTH_W(2)) bus ();

  fighter_player_ctrl #(
    .HEALTH_W(2), .HEALTH_INIT(3), .NUM_POS(3), .START_POS(0),
    .PUNCH_RANGE(1), .KICK_RANGE(2), .PUNCH_DMG(1), .KICK_DMG(2),
    .JUMP_CYCLES(2), .ATK_COOLDOWN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] a);
    bus.act_valid = v;
    bus.act       = a;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.act_valid    = 1'b0;
    bus.act          = WAIT;
    bus.opp_pos      = 2'd1;
    bus.opp_airborne = 1'b0;
    bus.hit_in       = 1'b0;
    bus.hit_dmg      = 2'd0;

    // Asynchronous reset before the first clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_pos",    int'(bus.pos), 0);
    check("rst_health", int'(bus.health), 3);
    check("rst_ko",     int'(bus.ko), 0);
    check("rst_busy",   int'(bus.busy), 0);
    check("rst_strike", int'(bus.strike), 0);
    check("rst_sdmg",   int'(bus.strike_dmg), 0);
    check("rst_air",    int'(bus.airborne), 0);
    step();
    step();
    rst = 1'b0;

    // Punch in range
    bus.opp_pos = 2'd1;
    drive(1'b1, PUNCH);
    step();
    drive(1'b0, WAIT);
    check("punch_strike", int'(bus.strike), 1);
    check("punch_dmg",    int'(bus.strike_dmg), 1);
    check("punch_busy",   int'(bus.busy), 1);
    step();
    check("punch_strike_off", int'(bus.strike), 0);
    check("punch_dmg_off",    int'(bus.strike_dmg), 0);
    check("punch_busy_off",   int'(bus.busy), 0);

    // Kick at range 2
    bus.opp_pos = 2'd2;
    drive(1'b1, KICK);
    step();
    drive(1'b0, WAIT);
    check("kick2_strike", int'(bus.strike), 1);
    check("kick2_dmg",    int'(bus.strike_dmg), 2);
    step();

    // Punch out of range
    drive(1'b1, PUNCH);
    step();
    drive(1'b0, WAIT);
    check("punch2_strike", int'(bus.strike), 0);
    check("punch2_dmg",    int'(bus.strike_dmg), 0);
    check("punch2_busy",   int'(bus.busy), 1);
    step();

    // Kick against airborne opponent
    bus.opp_pos      = 2'd1;
    bus.opp_airborne = 1'b1;
    drive(1'b1, KICK);
    step();
    drive(1'b0, WAIT);
    bus.opp_airborne = 1'b0;
    check("kick_air_strike", int'(bus.strike), 0);
    step();

    // Movement
    drive(1'b1, LEFT);
    step();
    check("left_sat", int'(bus.pos), 0);
    bus.opp_pos = 2'd2;
    drive(1'b1, RIGHT);
    step();
    check("right_0_1", int'(bus.pos), 1);
    step();
    check("right_blocked", int'(bus.pos), 1);
    bus.opp_pos = 2'd0;
    step();
    check("right_1_2", int'(bus.pos), 2);
    step();
    check("right_sat", int'(bus.pos), 2);
    drive(1'b1, 3'b110);
    step();
    check("code6_wait", int'(bus.pos), 2);
    check("code6_busy", int'(bus.busy), 0);

    // Jump window: hits and punches ignored while airborne
    bus.opp_pos = 2'd1;
    drive(1'b1, JUMP);
    step();
    check("jump_air1", int'(bus.airborne), 1);
    check("jump_busy1", int'(bus.busy), 1);
    drive(1'b1, PUNCH);
    bus.hit_in  = 1'b1;
    bus.hit_dmg = 2'd2;
    step();
    check("jump_air2",    int'(bus.airborne), 1);
    check("jump_health2", int'(bus.health), 3);
    check("jump_strike2", int'(bus.strike), 0);
    step();
    check("jump_air3",    int'(bus.airborne), 0);
    check("jump_health3", int'(bus.health), 3);
    check("jump_strike3", int'(bus.strike), 0);
    check("jump_busy3",   int'(bus.busy), 0);
    drive(1'b0, WAIT);
    bus.hit_in = 1'b0;
    step();

    // Knockout with saturation
    bus.hit_in  = 1'b1;
    bus.hit_dmg = 2'd2;
    step();
    check("ko_health1", int'(bus.health), 1);
    check("ko_flag1",   int'(bus.ko), 0);
    step();
    check("ko_health0", int'(bus.health), 0);
    check("ko_flag",    int'(bus.ko), 1);
    check("ko_busy",    int'(bus.busy), 1);

    // Sticky KO: further actions and hits change nothing
    bus.hit_dmg = 2'd1;
    drive(1'b1, LEFT);
    bus.opp_pos = 2'd0;
    step();
    drive(1'b1, PUNCH);
    bus.opp_pos = 2'd1;
    step();
    check("ko_pos",    int'(bus.pos), 2);
    check("ko_strike", int'(bus.strike), 0);
    check("ko_hold",   int'(bus.ko), 1);
    check("ko_hp",     int'(bus.health), 0);
    drive(1'b0, WAIT);
    bus.hit_in = 1'b0;
    step();
    check("ko_hold2", int'(bus.ko), 1);

    // Asynchronous reset mid-cycle clears KO without a clock edge
    #2 rst = 1'b1;
    #1;
    check("arst_pos",    int'(bus.pos), 0);
    check("arst_health", int'(bus.health), 3);
    check("arst_ko",     int'(bus.ko), 0);
    check("arst_busy",   int'(bus.busy), 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ko", int'(bus.ko), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fighter_player_ctrl.md
Name: fighter_player_ctrl

Overview:
Parametrised per-player controller for the two-player fighting game. Each cycle it takes one action command, tracks the player's position on a 1-D arena, runs jump and attack timing, and generates strike pulses toward the opponent. It also applies incoming hits to a saturating health counter and latches knockout.
Two instances are cross-connected at the game top level: each instance's `pos`, `airborne`, `strike` and `strike_dmg` feed the other instance's `opp_pos`, `opp_airborne`, `hit_in` and `hit_dmg`.

Parameters:
- HEALTH_W, 2, width of the health counter.
- HEALTH_INIT, 3, health value loaded at reset; must be nonzero and fit in HEALTH_W.
- NUM_POS, 3, number of arena positions; POS_W = clog2(NUM_POS), minimum 1.
- START_POS, 0, position loaded at reset.
- PUNCH_RANGE, 1, maximum |pos-opp_pos| at which a punch lands.
- KICK_RANGE, 2, maximum |pos-opp_pos| at which a kick lands.
- PUNCH_DMG, 1, damage carried by a punch; width HEALTH_W.
- KICK_DMG, 2, damage carried by a kick; width HEALTH_W.
- JUMP_CYCLES, 2, number of cycles spent airborne; must be at least 1.
- ATK_COOLDOWN, 1, busy cycles after an attack; 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- act_valid  in  1  qualifies act.
- act  in  3  action code: kick 000, punch 001, wait 010, jump 011, left 100, right 101; 110 and 111 are treated as wait.
- opp_pos  in  POS_W  opponent position.
- opp_airborne  in  1  opponent is mid-jump.
- hit_in  in  1  one-cycle strike from the opponent.
- hit_dmg  in  HEALTH_W  damage accompanying hit_in.
- pos  out  POS_W  current position.
- airborne  out  1  high while in the JUMP state.
- busy  out  1  high in JUMP, COOL and KO; actions are ignored while busy.
- strike  out  1  one-cycle pulse when an attack lands.
- strike_dmg  out  HEALTH_W  damage of the landed attack; valid only with strike, 0 otherwise.
- health  out  HEALTH_W  remaining health.
- ko  out  1  sticky knockout flag.

Behaviour:
Reset values: pos=START_POS, health=HEALTH_INIT, state=IDLE, airborne=0, busy=0, strike=0, strike_dmg=0, ko=0. Reset asserted mid-jump or mid-cooldown aborts immediately to these values.

State machine: IDLE, JUMP, COOL, KO.
- IDLE + act_valid, kick or punch:
  - strike is registered, asserted the cycle after acceptance, only if |pos-opp_pos| <= the action's range and opp_airborne=0 at acceptance.
  - strike_dmg is set to the action's damage in that same cycle.
  - Go to COOL if ATK_COOLDOWN>0, else stay in IDLE.
- IDLE + jump: go to JUMP. airborne is high for exactly JUMP_CYCLES cycles, then the state returns to IDLE.
- IDLE + left: pos-1. Saturates at 0.
- IDLE + right: pos+1. Saturates at NUM_POS-1.
- Blocking: a move whose target equals opp_pos is blocked and pos is unchanged.
- IDLE + wait, or act_valid=0: no change.
- COOL: counts ATK_COOLDOWN cycles, then returns to IDLE.
- Busy states: act_valid is ignored and not queued.
- Counters: jump and cooldown share a single down-counter, loaded on entry to JUMP or COOL.

Health:
- Update rule: on hit_in with airborne=0 and ko=0, health <= max(health-hit_dmg, 0).
- Airborne: hit_in is ignored while airborne.
- Knockout: when health reaches 0, the next state is KO and ko=1. KO is sticky until rst.
- In KO: strike=0, no moves, busy=1.
- Simultaneous events: an own attack accepted in the same cycle as an incoming hit is still evaluated. Its strike may fire even if that hit causes KO; this is a double-KO tie resolved by the top level.
- Width rule: the health subtraction is done in HEALTH_W+1 bits, then clamped to 0.
- Distance: computed unsigned as |a-b| in POS_W+1 bits.

Decomposition:
- Shared package fighter_pkg holds:
  - the action code localparams (KICK, PUNCH, WAIT, JUMP, LEFT, RIGHT);
  - the state enum (ST_IDLE, ST_JUMP, ST_COOL, ST_KO);
  - a distance function.
- Sub-module fighter_timer: loadable down-counter with load value, width and a done flag. Used for both jump and cooldown.

Test Plan:
1. Reset defaults. rst pulse asserted asynchronously mid-cycle -> pos=0, health=3, ko=0, busy=0 immediately, without waiting for a clock edge.
2. Punch in range. pos=0, opp_pos=1, act=punch -> strike=1, strike_dmg=1 for one cycle, then busy=1 for 1 cycle.
3. Range and dodge.
   - Kick with opp_pos=2 -> strike=1, dmg=2.
   - Punch with opp_pos=2 -> no strike.
   - Kick with opp_airborne=1 -> no strike.
4. Movement.
   - left at pos=0 -> pos stays 0.
   - right at pos=1 with opp_pos=2 -> pos stays 1 (blocked).
   - right at pos=1 with opp_pos=0 -> pos=2.
5. Jump window. act=jump -> airborne=1 for exactly 2 cycles.
   - hit_in during the jump -> health unchanged.
   - punch issued while airborne -> ignored.
6. Knockout. health=3, hit_in with dmg=2 twice -> health 1 then 0 (saturated), ko=1.
   - Further act and hit_in -> no change.
   - Only rst clears ko.
